// File: rtl/flash_cmd_pkg.sv
// Shared flash command definitions: opcodes, transfer lengths, sequencer states.
// Latency: none (package of constants, types and a pure helper function).
// Backpressure: none.
package flash_cmd_pkg;

    localparam int unsigned SPI_DATA_W = 128;

    localparam logic [7:0] OP_WREN       = 8'h06;
    localparam logic [7:0] OP_CHIP_ERASE = 8'hC7;
    localparam logic [7:0] OP_RDSR       = 8'h05;

    localparam logic [7:0] LEN_CMD  = 8'd8;   // bare opcode
    localparam logic [7:0] LEN_RDSR = 8'd16;  // opcode + one status byte clocked back

    typedef enum logic [3:0] {
        IDLE,
        WREN_GO,
        WREN_WAIT,
        ERASE_GO,
        ERASE_WAIT,
        GAP,
        POLL_GO,
        POLL_WAIT,
        CHECK,
        FINISH
    } erase_state_t;

    // Right-align a short command so its last bit is shifted out from bit 0.
    function automatic logic [SPI_DATA_W-1:0] cmd_frame(input logic [15:0] bits);
        return {{(SPI_DATA_W-16){1'b0}}, bits};
    endfunction

endpackage

// File: rtl/flash_xfer_wait.sv
// One SPI transfer: registered launch pulse, then wait for controller busy to rise and fall.
// Latency: spi_trig one cycle after launch; xfer_ok/xfer_timeout are same-cycle decodes of the phase.
// Backpressure: waits indefinitely for busy to fall; gives up after WIP_GUARD cycles if busy never rises.
module flash_xfer_wait #(
    parameter int unsigned WIP_GUARD = 15
) (
    input  logic sclk,
    input  logic rst_n,
    input  logic launch,
    input  logic spi_busy,
    output logic spi_trig,
    output logic xfer_ok,
    output logic xfer_timeout
);

    typedef enum logic [1:0] {PH_IDLE, PH_RISE, PH_FALL} phase_t;

    phase_t      phase_q, phase_d;
    logic        trig_q, trig_d;
    logic [15:0] guard_q, guard_d;

    // Phase tracking: arm on the trigger, look for busy rise (guarded), then for busy fall.
    always_comb begin
        trig_d       = launch;
        phase_d      = phase_q;
        guard_d      = guard_q;
        xfer_ok      = 1'b0;
        xfer_timeout = 1'b0;
        case (phase_q)
            PH_IDLE: begin
                if (trig_q) begin
                    phase_d = PH_RISE;
                    guard_d = 16'd0;
                end
            end
            PH_RISE: begin
                if (spi_busy) begin
                    phase_d = PH_FALL;
                end else if ((32'(guard_q) + 32'd1) >= WIP_GUARD) begin
                    xfer_timeout = 1'b1;
                    phase_d      = PH_IDLE;
                end else begin
                    guard_d = guard_q + 16'd1;
                end
            end
            PH_FALL: begin
                if (!spi_busy) begin
                    xfer_ok = 1'b1;
                    phase_d = PH_IDLE;
                end
            end
            default: phase_d = PH_IDLE;
        endcase
    end

    // State registers.
    always_ff @(posedge sclk or negedge rst_n) begin
        if (!rst_n) begin
            phase_q <= PH_IDLE;
            trig_q  <= 1'b0;
            guard_q <= 16'd0;
        end else begin
            phase_q <= phase_d;
            trig_q  <= trig_d;
            guard_q <= guard_d;
        end
    end

    assign spi_trig = trig_q;

endmodule

// File: rtl/flash_erase_seq.sv
// Full chip erase sequencer: WREN, CHIP ERASE, then RDSR polling until WIP clears.
// Latency: trig one cycle after start; done/fail one cycle after the deciding CHECK or guard expiry.
// Backpressure: start accepted only in IDLE with spi_busy low; otherwise dropped.
module flash_erase_seq #(
    parameter int unsigned POLL_GAP  = 50000,
    parameter int unsigned MAX_POLLS = 4000,
    parameter int unsigned WIP_GUARD = 15
) (
    input  logic         sclk,
    input  logic         rst_n,
    input  logic         start,
    input  logic         spi_busy,
    input  logic [127:0] spi_recvdata,
    output logic         spi_trig,
    output logic [7:0]   spi_datalength,
    output logic [127:0] spi_senddata,
    output logic         busy,
    output logic         done,
    output logic         fail,
    output logic [7:0]   status
);
    import flash_cmd_pkg::*;

    erase_state_t  state_q, state_d;
    logic [7:0]    len_q, len_d;
    logic [127:0]  data_q, data_d;
    logic [7:0]    status_q, status_d;
    logic [15:0]   poll_q, poll_d;
    logic [31:0]   gap_q, gap_d;
    logic          done_q, done_d;
    logic          fail_q, fail_d;
    logic          busy_q, busy_d;

    logic          launch;
    logic          xfer_ok;
    logic          xfer_timeout;
    logic          recv_unused;

    // Only the status byte of the RDSR response is meaningful.
    assign recv_unused = ^spi_recvdata[127:8];

    // Next-state and datapath decode for the erase sequence.
    always_comb begin
        state_d  = state_q;
        len_d    = len_q;
        data_d   = data_q;
        status_d = status_q;
        poll_d   = poll_q;
        gap_d    = gap_q;
        done_d   = 1'b0;
        fail_d   = fail_q;
        case (state_q)
            IDLE: begin
                if (start && !spi_busy) begin
                    state_d = WREN_GO;
                    fail_d  = 1'b0;
                    poll_d  = 16'd0;
                    len_d   = LEN_CMD;
                    data_d  = cmd_frame({8'h00, OP_WREN});
                end
            end
            WREN_GO:  state_d = WREN_WAIT;
            WREN_WAIT: begin
                if (xfer_timeout) begin
                    state_d = FINISH;
                    fail_d  = 1'b1;
                end else if (xfer_ok) begin
                    state_d = ERASE_GO;
                    len_d   = LEN_CMD;
                    data_d  = cmd_frame({8'h00, OP_CHIP_ERASE});
                end
            end
            ERASE_GO: state_d = ERASE_WAIT;
            ERASE_WAIT: begin
                if (xfer_timeout) begin
                    state_d = FINISH;
                    fail_d  = 1'b1;
                end else if (xfer_ok) begin
                    state_d = GAP;
                    gap_d   = 32'd0;
                end
            end
            GAP: begin
                if ((gap_q + 32'd1) >= POLL_GAP) begin
                    state_d = POLL_GO;
                    len_d   = LEN_RDSR;
                    data_d  = cmd_frame({OP_RDSR, 8'h00});
                end else begin
                    gap_d = gap_q + 32'd1;
                end
            end
            POLL_GO:  state_d = POLL_WAIT;
            POLL_WAIT: begin
                if (xfer_timeout) begin
                    state_d = FINISH;
                    fail_d  = 1'b1;
                end else if (xfer_ok) begin
                    state_d  = CHECK;
                    status_d = spi_recvdata[7:0];
                    poll_d   = (poll_q == 16'hFFFF) ? poll_q : poll_q + 16'd1;
                end
            end
            CHECK: begin
                // WIP clear wins; WEL is only meaningful on the first read after CHIP ERASE.
                if (!status_q[0]) begin
                    state_d = FINISH;
                    done_d  = 1'b1;
                end else if (!status_q[1] && (poll_q == 16'd1)) begin
                    state_d = FINISH;
                    fail_d  = 1'b1;
                end else if (32'(poll_q) >= MAX_POLLS) begin
                    state_d = FINISH;
                    fail_d  = 1'b1;
                end else begin
                    state_d = GAP;
                    gap_d   = 32'd0;
                end
            end
            FINISH:   state_d = IDLE;
            default:  state_d = IDLE;
        endcase
    end

    // Launch a transfer in the same cycle the sequencer sits in a *_GO state.
    always_comb begin
        launch = (state_d == WREN_GO) || (state_d == ERASE_GO) || (state_d == POLL_GO);
        busy_d = (state_d != IDLE);
    end

    // State and output registers.
    always_ff @(posedge sclk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= IDLE;
            len_q    <= 8'd0;
            data_q   <= 128'd0;
            status_q <= 8'd0;
            poll_q   <= 16'd0;
            gap_q    <= 32'd0;
            done_q   <= 1'b0;
            fail_q   <= 1'b0;
            busy_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            len_q    <= len_d;
            data_q   <= data_d;
            status_q <= status_d;
            poll_q   <= poll_d;
            gap_q    <= gap_d;
            done_q   <= done_d;
            fail_q   <= fail_d;
            busy_q   <= busy_d;
        end
    end

    flash_xfer_wait #(
        .WIP_GUARD (WIP_GUARD)
    ) u_xfer (
        .sclk         (sclk),
        .rst_n        (rst_n),
        .launch       (launch),
        .spi_busy     (spi_busy),
        .spi_trig     (spi_trig),
        .xfer_ok      (xfer_ok),
        .xfer_timeout (xfer_timeout)
    );

    assign spi_datalength = len_q;
    assign spi_senddata   = data_q;
    assign busy           = busy_q;
    assign done           = done_q;
    assign fail           = fail_q;
    assign status         = status_q;

endmodule

// File: tb/tb_flash_erase_seq.sv
// Bench for flash_erase_seq: two instances (default poll limit and a limit of 3) with controller models.
// Latency: n/a.
// Backpressure: n/a.
module tb_flash_erase_seq;

    logic         sclk = 1'b0;
    logic         rst_n;
    logic [1:0]   start_v;
    logic [1:0]   busy_m;
    logic [1:0]   force_busy;
    logic [1:0]   spi_busy_v;
    logic [127:0] recv_v [2];
    logic [1:0]   trig_v;
    logic [7:0]   len_v [2];
    logic [127:0] send_v [2];
    logic [1:0]   busy_v;
    logic [1:0]   done_v;
    logic [1:0]   fail_v;
    logic [7:0]   status_v [2];

    always #5 sclk = ~sclk;

    assign spi_busy_v = busy_m | force_busy;

    flash_erase_seq #(.POLL_GAP(4), .MAX_POLLS(4000), .WIP_GUARD(15)) dut (
        .sclk(sclk), .rst_n(rst_n), .start(start_v[0]), .spi_busy(spi_busy_v[0]),
        .spi_recvdata(recv_v[0]), .spi_trig(trig_v[0]), .spi_datalength(len_v[0]),
        .spi_senddata(send_v[0]), .busy(busy_v[0]), .done(done_v[0]), .fail(fail_v[0]),
        .status(status_v[0])
    );

    flash_erase_seq #(.POLL_GAP(4), .MAX_POLLS(3), .WIP_GUARD(15)) dut3 (
        .sclk(sclk), .rst_n(rst_n), .start(start_v[1]), .spi_busy(spi_busy_v[1]),
        .spi_recvdata(recv_v[1]), .spi_trig(trig_v[1]), .spi_datalength(len_v[1]),
        .spi_senddata(send_v[1]), .busy(busy_v[1]), .done(done_v[1]), .fail(fail_v[1]),
        .status(status_v[1])
    );

    // Controller model state (written only by the model process).
    int           trig_cnt [2];
    int           done_cnt [2];
    logic         both_seen [2];
    int           dly [2];
    int           bcnt [2];
    int           pidx [2];
    int           clr_seen [2];
    logic [7:0]   tlen [2][16];
    logic [127:0] tdat [2][16];

    // Model configuration (written only by the stimulus process).
    int           clr_gen [2];
    logic         nobusy [2];
    logic [7:0]   stat_tab [2][4];
    int           stat_n [2];

    // SPI controller model: busy rises 2 cycles after trig and stays high 20 cycles.
    always @(negedge sclk) begin
        for (int g = 0; g < 2; g++) begin
            if (clr_seen[g] != clr_gen[g]) begin
                clr_seen[g]  = clr_gen[g];
                trig_cnt[g]  = 0;
                done_cnt[g]  = 0;
                both_seen[g] = 1'b0;
                dly[g]       = 0;
                bcnt[g]      = 0;
                pidx[g]      = 0;
                busy_m[g]    = 1'b0;
            end
            if (done_v[g]) done_cnt[g]++;
            if (done_v[g] && fail_v[g]) both_seen[g] = 1'b1;
            if (dly[g] > 0) begin
                dly[g]--;
                if (dly[g] == 0) begin
                    busy_m[g] = 1'b1;
                    bcnt[g]   = 20;
                end
            end else if (bcnt[g] > 0) begin
                bcnt[g]--;
                if (bcnt[g] == 0) busy_m[g] = 1'b0;
            end
            if (trig_v[g]) begin
                if (trig_cnt[g] < 16) begin
                    tlen[g][trig_cnt[g]] = len_v[g];
                    tdat[g][trig_cnt[g]] = send_v[g];
                end
                trig_cnt[g]++;
                if (!nobusy[g]) dly[g] = 2;
                if (len_v[g] == 8'd16) begin
                    recv_v[g] = {120'd0, stat_tab[g][pidx[g]]};
                    if (pidx[g] < stat_n[g] - 1) pidx[g]++;
                end
            end
        end
    end

    typedef struct {
        int         sel;
        int         n;
        logic [31:0] st;          // status bytes per poll, poll 1 in [7:0]
        logic       extra;        // pulse start again mid-sequence
        int         exp_trig;
        int         exp_done;
        logic       exp_fail;
        logic [7:0] exp_status;
    } vec_t;

    vec_t vt [7];
    int   checks = 0;
    int   errors = 0;

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(negedge sclk);
        #1;
    endtask

    task automatic run_vec(input vec_t v, input int idx);
        int s;
        int cyc;
        int nt;
        logic [7:0]   el;
        logic [127:0] ed;
        s = v.sel;
        for (int i = 0; i < 4; i++) stat_tab[s][i] = v.st[8*i +: 8];
        stat_n[s] = v.n;
        clr_gen[s]++;
        tick();
        start_v[s] = 1'b1;
        tick();
        start_v[s] = 1'b0;
        check($sformatf("v%0d_busy_rise", idx), 128'(busy_v[s]), 128'd1);
        cyc = 0;
        while (busy_v[s] && cyc < 3000) begin
            tick();
            cyc++;
            start_v[s] = (v.extra && cyc == 40);
        end
        start_v[s] = 1'b0;
        check($sformatf("v%0d_end_in_time", idx), 128'(cyc < 3000), 128'd1);
        repeat (30) tick();
        check($sformatf("v%0d_trig_count", idx), 128'(trig_cnt[s]), 128'(v.exp_trig));
        check($sformatf("v%0d_done_count", idx), 128'(done_cnt[s]), 128'(v.exp_done));
        check($sformatf("v%0d_fail", idx), 128'(fail_v[s]), 128'(v.exp_fail));
        check($sformatf("v%0d_status", idx), 128'(status_v[s]), 128'(v.exp_status));
        check($sformatf("v%0d_busy_low", idx), 128'(busy_v[s]), 128'd0);
        check($sformatf("v%0d_done_fail_excl", idx), 128'(both_seen[s]), 128'd0);
        nt = (trig_cnt[s] < 16) ? trig_cnt[s] : 16;
        for (int i = 0; i < nt; i++) begin
            el = (i < 2) ? 8'd8 : 8'd16;
            ed = (i == 0) ? 128'h06 : (i == 1) ? 128'hC7 : 128'h0500;
            check($sformatf("v%0d_trig%0d_len", idx, i), 128'(tlen[s][i]), 128'(el));
            check($sformatf("v%0d_trig%0d_data", idx, i), tdat[s][i], ed);
        end
    endtask

    initial begin
        int cyc;
        vt[0] = '{0, 4, 32'h00030303, 1'b1, 6, 1, 1'b0, 8'h00};  // nominal, extra start ignored
        vt[1] = '{0, 1, 32'h00000001, 1'b0, 3, 0, 1'b1, 8'h01};  // WEL not latched on first poll
        vt[2] = '{0, 1, 32'h00000002, 1'b0, 3, 1, 1'b0, 8'h02};  // done on first poll, fail cleared
        vt[3] = '{0, 2, 32'h00000203, 1'b0, 4, 1, 1'b0, 8'h02};  // done on second poll
        vt[4] = '{0, 3, 32'h00000103, 1'b0, 5, 1, 1'b0, 8'h00};  // WEL=0 after first poll is ignored
        vt[5] = '{1, 1, 32'h00000003, 1'b0, 5, 0, 1'b1, 8'h03};  // MAX_POLLS=3 exhausted
        vt[6] = '{1, 2, 32'h00000003, 1'b0, 4, 1, 1'b0, 8'h00};  // done under the poll limit

        rst_n      = 1'b0;
        start_v    = 2'b00;
        force_busy = 2'b00;
        for (int g = 0; g < 2; g++) begin
            clr_gen[g] = 1;
            nobusy[g]  = 1'b0;
            stat_n[g]  = 1;
            for (int i = 0; i < 4; i++) stat_tab[g][i] = 8'h03;
        end
        #1;
        for (int g = 0; g < 2; g++) begin
            check($sformatf("rst%0d_trig", g), 128'(trig_v[g]), 128'd0);
            check($sformatf("rst%0d_len", g), 128'(len_v[g]), 128'd0);
            check($sformatf("rst%0d_send", g), send_v[g], 128'd0);
            check($sformatf("rst%0d_busy", g), 128'(busy_v[g]), 128'd0);
            check($sformatf("rst%0d_done_fail", g), 128'({done_v[g], fail_v[g]}), 128'd0);
            check($sformatf("rst%0d_status", g), 128'(status_v[g]), 128'd0);
        end
        repeat (3) tick();
        rst_n = 1'b1;
        tick();

        for (int i = 0; i < 7; i++) run_vec(vt[i], i);

        // Controller never raises busy: guard expiry in WREN_WAIT.
        nobusy[0] = 1'b1;
        clr_gen[0]++;
        tick();
        start_v[0] = 1'b1;
        tick();
        start_v[0] = 1'b0;
        cyc = 0;
        while (!trig_v[0] && cyc < 10) begin
            tick();
            cyc++;
        end
        check("guard_trig_seen", 128'(trig_v[0]), 128'd1);
        repeat (15) tick();
        check("guard_fail_before", 128'(fail_v[0]), 128'd0);
        tick();
        check("guard_fail_at", 128'(fail_v[0]), 128'd1);
        check("guard_busy_finish", 128'(busy_v[0]), 128'd1);
        tick();
        check("guard_busy_idle", 128'(busy_v[0]), 128'd0);
        check("guard_no_done", 128'(done_cnt[0]), 128'd0);
        check("guard_one_trig", 128'(trig_cnt[0]), 128'd1);
        nobusy[0] = 1'b0;

        // Start while the controller is busy in IDLE is dropped.
        clr_gen[0]++;
        force_busy[0] = 1'b1;
        tick();
        start_v[0] = 1'b1;
        tick();
        start_v[0] = 1'b0;
        repeat (5) tick();
        check("idle_busy_start_busy", 128'(busy_v[0]), 128'd0);
        check("idle_busy_start_trig", 128'(trig_cnt[0]), 128'd0);
        force_busy[0] = 1'b0;

        // Reset during GAP abandons the erase, then a fresh start runs from WREN.
        for (int i = 0; i < 4; i++) stat_tab[0][i] = vt[0].st[8*i +: 8];
        stat_n[0] = 4;
        clr_gen[0]++;
        tick();
        start_v[0] = 1'b1;
        tick();
        start_v[0] = 1'b0;
        cyc = 0;
        while (trig_cnt[0] < 2 && cyc < 500) begin tick(); cyc++; end
        while (!busy_m[0] && cyc < 500) begin tick(); cyc++; end
        while (busy_m[0] && cyc < 500) begin tick(); cyc++; end
        check("gap_reached", 128'(cyc < 500), 128'd1);
        repeat (2) tick();
        check("gap_busy_before_rst", 128'(busy_v[0]), 128'd1);
        rst_n = 1'b0;
        #1;
        check("gaprst_busy", 128'(busy_v[0]), 128'd0);
        check("gaprst_len", 128'(len_v[0]), 128'd0);
        check("gaprst_send", send_v[0], 128'd0);
        check("gaprst_trig_done_fail", 128'({trig_v[0], done_v[0], fail_v[0]}), 128'd0);
        repeat (3) tick();
        check("gaprst_no_traffic", 128'(trig_cnt[0]), 128'd2);
        check("gaprst_no_done", 128'(done_cnt[0]), 128'd0);
        check("gaprst_no_fail", 128'(fail_v[0]), 128'd0);
        rst_n = 1'b1;
        tick();
        run_vec(vt[0], 7);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
